// File: rtl/trakball_pkg.sv
// Shared types and constants for the trackball emulator: step FSM states,
// pending-accumulator geometry and its saturation helper.
package trakball_pkg;

    localparam int ACC_W   = 10;
    localparam int ACC_MAX = 511;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP_H = 2'd1,
        ST_STEP_V = 2'd2
    } step_state_e;

    localparam logic signed [ACC_W+1:0] SAT_HI = (ACC_W+2)'(ACC_MAX);
    localparam logic signed [ACC_W+1:0] SAT_LO = (ACC_W+2)'(-ACC_MAX);

    // Clamp a widened accumulator sum back into the symmetric +/-ACC_MAX range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[ACC_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[ACC_W-1:0];
        end
        return v[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/trakball_emu_axis.sv
// One trackball axis: pending accumulator fed by mouse deltas and joystick
// injection, drained one step at a time into a wrapping 4-bit count.
module trak_axis
    import trakball_pkg::*;
#(
    parameter int JOY_DIV     = 4,
    parameter int MOUSE_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_i,
    input  logic       pause_i,
    input  logic       accept_i,
    input  logic [8:0] delta_i,
    input  logic       joy_pos_i,
    input  logic       joy_neg_i,
    input  logic       step_i,
    output logic [3:0] count_o,
    output logic       dir_o,
    output logic       busy_o
);

    localparam int JW = $clog2(JOY_DIV + 1);
    localparam logic signed [ACC_W+1:0] ONE     = (ACC_W+2)'(1);
    localparam logic signed [ACC_W+1:0] NEG_ONE = '1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [JW-1:0]           joy_cnt_q, joy_cnt_d;
    logic [3:0]              count_q, count_d;
    logic                    dir_q, dir_d;

    logic signed [8:0]       delta_sh;
    logic signed [ACC_W+1:0] mouse_add, joy_add, step_add;

    always_comb begin
        delta_sh  = $signed(delta_i) >>> MOUSE_SHIFT;
        mouse_add = accept_i ? (ACC_W+2)'(delta_sh) : '0;

        joy_cnt_d = joy_cnt_q;
        joy_add   = '0;
        if (pause_i) begin
            joy_cnt_d = joy_cnt_q;
        end else if (!(joy_pos_i || joy_neg_i)) begin
            joy_cnt_d = '0;
        end else if (tick_i) begin
            if (joy_cnt_q == JW'(JOY_DIV - 1)) begin
                joy_cnt_d = '0;
                // Opposing directions still consume the period but cancel out.
                if (joy_pos_i && !joy_neg_i) begin
                    joy_add = ONE;
                end else if (joy_neg_i && !joy_pos_i) begin
                    joy_add = NEG_ONE;
                end
            end else begin
                joy_cnt_d = joy_cnt_q + 1'b1;
            end
        end

        count_d  = count_q;
        dir_d    = dir_q;
        step_add = '0;
        if (step_i) begin
            if (acc_q[ACC_W-1]) begin
                count_d  = count_q - 4'd1;
                dir_d    = 1'b1;
                step_add = ONE;
            end else if (acc_q != '0) begin
                count_d  = count_q + 4'd1;
                dir_d    = 1'b0;
                step_add = NEG_ONE;
            end
        end

        acc_d = sat_acc((ACC_W+2)'(acc_q) + mouse_add + joy_add + step_add);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            joy_cnt_q <= '0;
            count_q   <= '0;
            dir_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            joy_cnt_q <= joy_cnt_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
        end
    end

    assign count_o = count_q;
    assign dir_o   = dir_q;
    assign busy_o  = (acc_q != '0);

endmodule

// File: rtl/trakball_emu.sv
// Trackball emulator: converts mouse packets and joystick holds into the
// quadrature-style count/direction pair expected by the arcade core.
module trakball_emu
    import trakball_pkg::*;
#(
    parameter int CLK_DIV     = 1200,
    parameter int JOY_DIV     = 4,
    parameter int MOUSE_SHIFT = 1
) (
    input  logic       clk_12mhz,
    input  logic       reset_n,
    input  logic [3:0] joystick_i,
    input  logic [8:0] mouse_dx_i,
    input  logic [8:0] mouse_dy_i,
    input  logic       mouse_strobe_i,
    input  logic       pause_i,
    output logic [7:0] trakball_o,
    output logic [1:0] trak_dir_o,
    output logic       busy_o
);

    localparam int PW = $clog2(CLK_DIV + 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          strobe_q, strobe_d;
    logic          strobe_vld_q, strobe_vld_d;
    step_state_e   state_q, state_d;
    logic          tick, accept;
    logic [3:0]    h_count, v_count;
    logic          h_dir, v_dir, h_busy, v_busy;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (!pause_i) begin
            if (presc_q == PW'(CLK_DIV - 1)) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // The copy keeps tracking while paused so a release never replays a stale toggle.
        strobe_d     = mouse_strobe_i;
        strobe_vld_d = 1'b1;
        accept       = strobe_vld_q && (mouse_strobe_i != strobe_q) && !pause_i;

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick) state_d = ST_STEP_H;
            ST_STEP_H: state_d = ST_STEP_V;
            ST_STEP_V: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_12mhz or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            strobe_q     <= 1'b0;
            strobe_vld_q <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            presc_q      <= presc_d;
            strobe_q     <= strobe_d;
            strobe_vld_q <= strobe_vld_d;
            state_q      <= state_d;
        end
    end

    trak_axis #(.JOY_DIV(JOY_DIV), .MOUSE_SHIFT(MOUSE_SHIFT)) u_axis_h (
        .clk       (clk_12mhz),
        .reset_n   (reset_n),
        .tick_i    (tick),
        .pause_i   (pause_i),
        .accept_i  (accept),
        .delta_i   (mouse_dx_i),
        .joy_pos_i (!joystick_i[3]),
        .joy_neg_i (!joystick_i[2]),
        .step_i    (state_q == ST_STEP_H),
        .count_o   (h_count),
        .dir_o     (h_dir),
        .busy_o    (h_busy)
    );

    trak_axis #(.JOY_DIV(JOY_DIV), .MOUSE_SHIFT(MOUSE_SHIFT)) u_axis_v (
        .clk       (clk_12mhz),
        .reset_n   (reset_n),
        .tick_i    (tick),
        .pause_i   (pause_i),
        .accept_i  (accept),
        .delta_i   (mouse_dy_i),
        .joy_pos_i (!joystick_i[1]),
        .joy_neg_i (!joystick_i[0]),
        .step_i    (state_q == ST_STEP_V),
        .count_o   (v_count),
        .dir_o     (v_dir),
        .busy_o    (v_busy)
    );

    assign trakball_o = {v_count, h_count};
    assign trak_dir_o = {v_dir, h_dir};
    assign busy_o     = h_busy | v_busy;

endmodule
